ahb3lite_interconnect_slave_arbiter: RTL and testbench
======================================================

# ahb3lite_interconnect_slave_arbiter

Per-slave-port arbiter for the AHB3-Lite interconnect matrix: selects which requesting master owns the slave port for the next address phase. Selection is by highest master priority. Ownership is held across fixed-length bursts, undefined-length INCR bursts and locked sequences. Grants update only on accepted transfer boundaries (HREADY high). One instance sits in front of each slave port's address/data multiplexer.

## Interface
- MASTERS, 3, number of masters competing for this slave port (≥1)
- PRIORITY_BITS, $clog2(MASTERS) (min 1), width of each priority field; localparam in intent
- HCLK  in  1  clock; all state updates on rising edge
- HRESET  in  1  reset, synchronous, active-high
- HSEL  in  MASTERS  per-master request (master address decodes to this slave)
- priority_i  in  MASTERS×PRIORITY_BITS  per-master priority; larger value wins
- HTRANS  in  MASTERS×2  per-master transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
- HBURST  in  MASTERS×3  per-master burst type
- HMASTLOCK  in  MASTERS  per-master locked-sequence indication
- HREADY  in  1  slave-port HREADY; 1 = current address phase accepted
- grant_o  out  MASTERS  one-hot owner; all-zero when no owner
- grant_id_o  out  max(1,$clog2(MASTERS))  binary index of owner; 0 when no owner
- grant_valid_o  out  1  an owner exists

## Operation
- Candidates: masters with HSEL=1. Priority 0 is a valid priority; HSEL=0 excludes a master regardless of priority.
- Winner: maximum priority_i among candidates. Tie-break is governed by the Configuration macro.
- States: IDLE, OWNED, BURST, LOCKED. State is evaluated only on edges where HREADY=1. With HREADY=0, all state, counters and outputs hold.
- IDLE: no owner. Go to OWNED with the winner if any candidate exists; otherwise stay in IDLE.
- OWNED: owner presents a single transfer or idles. Each edge, rearbitrate:
  - new winner, or current owner if it is still the winner;
  - IDLE if there are no candidates.
- The owner's signals decide hold vs. rearbitrate. On an edge where the owner has HSEL=1:
  - HMASTLOCK=1 → LOCKED. Holds in any state and takes precedence over burst tracking.
  - NONSEQ with fixed burst (WRAP4/INCR4=3 beats remaining, 8→7, 16→15) → load beat counter, go to BURST.
  - NONSEQ or SEQ or BUSY with HBURST=INCR → BURST with incr flag set.
- BURST:
  - Accepted SEQ decrements the counter. BUSY does not decrement.
  - The owner holds while counter≠0, or while the incr flag is set and the owner presents SEQ/BUSY/NONSEQ-INCR.
  - On counter reaching 0, or incr flag set with owner IDLE, rearbitrate as in OWNED.
- Early termination, from BURST or LOCKED: owner HSEL=0, owner IDLE in a fixed burst, or owner NONSEQ in a fixed burst. Clear the counter and incr flag, then rearbitrate in the same edge. A NONSEQ that restarts a burst is re-evaluated against the load rules.
- LOCKED: hold while the owner has HMASTLOCK=1 and HSEL=1. On release, rearbitrate in the same edge.
- Reset: state IDLE, grant_o=0, grant_id_o=0, grant_valid_o=0, counter 0, incr flag 0, round-robin pointer MASTERS-1.

## Timing
- All outputs are registered. A grant decided at edge N is valid from edge N until the next qualifying edge.
- Arbitration latency: 1 cycle from HSEL assertion with HREADY=1 to grant_o.
- Owner handover occurs on the same edge that accepts the last beat. There is no dead cycle between owners.
- Simultaneous events:
  - Reset overrides everything.
  - HMASTLOCK overrides burst end.
  - Owner HSEL drop overrides hold.
- Reset asserted mid-burst or mid-lock: outputs go to their reset values at the next edge, independent of HREADY.

## Configuration
- AHB3LITE_SLAVE_ARB_RR_EN defined: ties at the maximum priority are resolved round-robin.
  - The first tied candidate above the pointer (wrapping) wins.
  - The pointer updates to the new owner index on every grant change.
- AHB3LITE_SLAVE_ARB_RR_EN undefined: the lowest-index tied candidate wins; the pointer is not implemented.

## Test plan
- Reset, then HSEL=3'b000 → grant_o=0, grant_valid_o=0. Then HSEL=3'b110, priority {2,1,0} (index 2..0), HREADY=1 → next edge grant_o=3'b100, grant_id_o=2.
- Master0 prio 0 owns, issues INCR4 NONSEQ; master2 prio 2 requests at beat 1 → master0 holds through 3 SEQ beats. This includes one BUSY and one HREADY=0 stall. Master2 is granted on the edge accepting beat 4.
- Master1 HMASTLOCK=1 for 5 transfers while higher-priority master2 requests → grant_o stays 3'b010 until HMASTLOCK falls. Then 3'b100 on the same edge.
- Equal priorities 1,1,1 with all HSEL=1 and single transfers → with the RR macro, grants cycle 0,1,2,0. Without the macro, grant stays 0.
- Owner master0 in INCR8 drops HSEL after 3 beats → counter clears, master1 is granted next edge.
- HRESET asserted mid-LOCKED → next edge all outputs 0 and state IDLE, even with HREADY=0.

Source files
------------

// File: rtl/ahb3lite_interconnect_slave_arbiter_if.sv
// ============================================================================
// Module   : ahb3lite_interconnect_slave_arbiter_if
// Purpose  : Request/grant bundle between the masters and one slave-port arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface ahb3lite_interconnect_slave_arbiter_if #(
    parameter int MASTERS       = 3,
    parameter int PRIORITY_BITS = (MASTERS > 1) ? $clog2(MASTERS) : 1
);
    localparam int ID_BITS = (MASTERS > 1) ? $clog2(MASTERS) : 1;

    logic [MASTERS-1:0]               HSEL;
    logic [MASTERS*PRIORITY_BITS-1:0] priority_i;
    logic [2*MASTERS-1:0]             HTRANS;
    logic [3*MASTERS-1:0]             HBURST;
    logic [MASTERS-1:0]               HMASTLOCK;
    logic                             HREADY;
    logic [MASTERS-1:0]               grant_o;
    logic [ID_BITS-1:0]               grant_id_o;
    logic                             grant_valid_o;

    modport slave (
        input  HSEL, priority_i, HTRANS, HBURST, HMASTLOCK, HREADY,
        output grant_o, grant_id_o, grant_valid_o
    );

    modport master (
        output HSEL, priority_i, HTRANS, HBURST, HMASTLOCK, HREADY,
        input  grant_o, grant_id_o, grant_valid_o
    );
endinterface

`default_nettype wire

// File: rtl/ahb3lite_interconnect_slave_arbiter.sv
// ============================================================================
// Module   : ahb3lite_interconnect_slave_arbiter
// Purpose  : Priority arbiter for one AHB3-Lite slave port; holds ownership over
//            bursts and locked sequences. Define AHB3LITE_SLAVE_ARB_RR_EN for
//            round-robin tie-break (default: lowest index wins ties).
// Revision : 1.0
// ============================================================================
`default_nettype none

module ahb3lite_interconnect_slave_arbiter #(
    parameter int MASTERS       = 3,
    parameter int PRIORITY_BITS = (MASTERS > 1) ? $clog2(MASTERS) : 1
) (
    input  logic                                  HCLK,
    input  logic                                  HRESET,
    ahb3lite_interconnect_slave_arbiter_if.slave  bus
);
    localparam int         ID_BITS   = (MASTERS > 1) ? $clog2(MASTERS) : 1;
    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;
    localparam logic [2:0] HB_INCR   = 3'b001;

    typedef enum logic [1:0] {ST_IDLE, ST_OWNED, ST_BURST, ST_LOCKED} state_t;

    state_t                   state, state_nxt;
    logic [MASTERS-1:0]       grant, grant_nxt;
    logic [ID_BITS-1:0]       owner, owner_nxt;
    logic                     valid, valid_nxt;
    logic [3:0]               beats, beats_nxt;
    logic                     incr, incr_nxt;
    logic                     rearb, evaluate;

    logic [PRIORITY_BITS-1:0] pri [MASTERS];
    logic                     any_cand;
    logic [PRIORITY_BITS-1:0] max_pri;
    logic [ID_BITS-1:0]       first_max, winner;

    logic                     own_sel, own_lock;
    logic [1:0]               own_trans;
    logic [2:0]               own_burst;
    logic [3:0]               own_load;

    generate
        for (genvar g = 0; g < MASTERS; g++) begin : g_pri
            assign pri[g] = bus.priority_i[g*PRIORITY_BITS +: PRIORITY_BITS];
        end
    endgenerate

    // Strict '>' keeps the lowest index among equal maxima.
    always_comb begin
        any_cand  = 1'b0;
        max_pri   = '0;
        first_max = '0;
        for (int i = 0; i < MASTERS; i++) begin
            if (bus.HSEL[i] && (!any_cand || pri[i] > max_pri)) begin
                any_cand  = 1'b1;
                max_pri   = pri[i];
                first_max = ID_BITS'(i);
            end
        end
    end

`ifdef AHB3LITE_SLAVE_ARB_RR_EN
    logic [ID_BITS-1:0] rr_ptr;
    logic               rr_found;
    int                 rr_idx;

    always_comb begin
        winner   = first_max;
        rr_found = 1'b0;
        rr_idx   = 0;
        for (int k = 1; k <= MASTERS; k++) begin
            rr_idx = int'(rr_ptr) + k;
            if (rr_idx >= MASTERS) rr_idx = rr_idx - MASTERS;
            for (int j = 0; j < MASTERS; j++) begin
                if (!rr_found && rr_idx == j && bus.HSEL[j] && pri[j] == max_pri) begin
                    winner   = ID_BITS'(j);
                    rr_found = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET)
            rr_ptr <= ID_BITS'(MASTERS - 1);
        else if (owner_nxt != owner || valid_nxt != valid)
            if (valid_nxt) rr_ptr <= owner_nxt;
    end
`else
    assign winner = first_max;
`endif

    always_comb begin
        own_sel   = 1'b0;
        own_lock  = 1'b0;
        own_trans = TR_IDLE;
        own_burst = 3'b000;
        for (int i = 0; i < MASTERS; i++) begin
            if (owner == ID_BITS'(i)) begin
                own_sel   = bus.HSEL[i];
                own_lock  = bus.HMASTLOCK[i];
                own_trans = bus.HTRANS[2*i +: 2];
                own_burst = bus.HBURST[3*i +: 3];
            end
        end
        case (own_burst)
            3'b010, 3'b011: own_load = 4'd3;
            3'b100, 3'b101: own_load = 4'd7;
            3'b110, 3'b111: own_load = 4'd15;
            default:        own_load = 4'd0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        grant_nxt = grant;
        valid_nxt = valid;
        beats_nxt = beats;
        incr_nxt  = incr;
        rearb     = 1'b0;
        evaluate  = 1'b0;
        if (bus.HREADY) begin
            case (state)
                ST_IDLE:  rearb = 1'b1;
                ST_OWNED: evaluate = 1'b1;
                ST_BURST: begin
                    // A NONSEQ inside a burst ends it but may itself start a new one.
                    if (!own_sel)                                rearb = 1'b1;
                    else if (own_lock || own_trans == TR_NONSEQ) evaluate = 1'b1;
                    else if (own_trans == TR_IDLE)               rearb = 1'b1;
                    else if (!incr && own_trans == TR_SEQ) begin
                        if (beats <= 4'd1) rearb = 1'b1;
                        else               beats_nxt = beats - 4'd1;
                    end
                end
                ST_LOCKED: if (!(own_sel && own_lock)) rearb = 1'b1;
                default:   rearb = 1'b1;
            endcase

            if (evaluate) begin
                if (own_sel && own_lock) begin
                    state_nxt = ST_LOCKED;
                    beats_nxt = 4'd0;
                    incr_nxt  = 1'b0;
                end else if (own_sel && own_trans == TR_NONSEQ && own_load != 4'd0) begin
                    state_nxt = ST_BURST;
                    beats_nxt = own_load;
                    incr_nxt  = 1'b0;
                end else if (own_sel && own_burst == HB_INCR && own_trans != TR_IDLE) begin
                    state_nxt = ST_BURST;
                    beats_nxt = 4'd0;
                    incr_nxt  = 1'b1;
                end else begin
                    rearb = 1'b1;
                end
            end

            if (rearb) begin
                beats_nxt = 4'd0;
                incr_nxt  = 1'b0;
                state_nxt = any_cand ? ST_OWNED : ST_IDLE;
                owner_nxt = any_cand ? winner : '0;
                valid_nxt = any_cand;
                for (int i = 0; i < MASTERS; i++)
                    grant_nxt[i] = any_cand && (winner == ID_BITS'(i));
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state <= ST_IDLE;
            grant <= '0;
            owner <= '0;
            valid <= 1'b0;
            beats <= 4'd0;
            incr  <= 1'b0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            owner <= owner_nxt;
            valid <= valid_nxt;
            beats <= beats_nxt;
            incr  <= incr_nxt;
        end
    end

    assign bus.grant_o       = grant;
    assign bus.grant_id_o    = owner;
    assign bus.grant_valid_o = valid;
endmodule

`default_nettype wire

// File: tb/tb_ahb3lite_interconnect_slave_arbiter.sv
// ============================================================================
// Module   : tb_ahb3lite_interconnect_slave_arbiter
// Purpose  : Scoreboard bench for the slave-port arbiter (directed + random).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ahb3lite_interconnect_slave_arbiter;
    localparam int M  = 3;
    localparam int PB = 2;
    localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NS = 2'b10, SEQ = 2'b11;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [M-1:0]    hsel, lock;
    logic [M*PB-1:0] pri_v;
    logic [2*M-1:0]  trans_v;
    logic [3*M-1:0]  burst_v;
    logic            hready;

    ahb3lite_interconnect_slave_arbiter_if #(.MASTERS(M)) ifc();
    assign ifc.HSEL       = hsel;
    assign ifc.priority_i = pri_v;
    assign ifc.HTRANS     = trans_v;
    assign ifc.HBURST     = burst_v;
    assign ifc.HMASTLOCK  = lock;
    assign ifc.HREADY     = hready;

    ahb3lite_interconnect_slave_arbiter #(.MASTERS(M)) dut (
        .HCLK   (clk),
        .HRESET (rst),
        .bus    (ifc)
    );

    typedef struct {
        int           cyc;
        logic [M-1:0] g;
        logic [1:0]   id;
        logic         v;
    } exp_t;

    exp_t sb[$];
    int   cycle  = 0;
    int   checks = 0;
    int   errors = 0;
    always @(posedge clk) cycle <= cycle + 1;

    // Reference model: who owns the port and what it still has left to finish.
    int m_owner = -1;
    int m_left  = 0;
    int m_ptr   = M - 1;
    bit m_incr  = 1'b0;
    bit m_lock  = 1'b0;

    function automatic int prio_of(int i);
        return int'(pri_v[i*PB +: PB]);
    endfunction

    function automatic int fixed_len(logic [2:0] hb);
        case (hb)
            3'd2, 3'd3: return 4;
            3'd4, 3'd5: return 8;
            3'd6, 3'd7: return 16;
            default:    return 0;
        endcase
    endfunction

    function automatic int pick();
        int best  = -1;
        int bestp = -1;
        for (int i = 0; i < M; i++)
            if (hsel[i] && prio_of(i) > bestp) begin
                best  = i;
                bestp = prio_of(i);
            end
`ifdef AHB3LITE_SLAVE_ARB_RR_EN
        if (best >= 0) begin
            best = -1;
            for (int k = 1; k <= M; k++) begin
                int idx = (m_ptr + k) % M;
                if (best < 0 && hsel[idx] && prio_of(idx) == bestp) best = idx;
            end
        end
`endif
        return best;
    endfunction

    task automatic model_edge();
        bit         keep;
        bit         in_burst;
        int         prev;
        logic [1:0] t;
        logic [2:0] b;
        keep = 1'b0;
        if (rst) begin
            m_owner = -1; m_left = 0; m_incr = 1'b0; m_lock = 1'b0; m_ptr = M - 1;
        end else if (hready) begin
            if (m_owner >= 0) begin
                t        = trans_v[2*m_owner +: 2];
                b        = burst_v[3*m_owner +: 3];
                in_burst = (m_left > 0) || m_incr;
                if (!hsel[m_owner])               keep = 1'b0;
                else if (lock[m_owner]) begin
                    keep = 1'b1; m_lock = 1'b1; m_left = 0; m_incr = 1'b0;
                end
                else if (m_lock)                  keep = 1'b0;
                else if (in_burst && t == BUSY)   keep = 1'b1;
                else if (in_burst && t == SEQ) begin
                    if (m_incr) keep = 1'b1;
                    else begin
                        m_left = m_left - 1;
                        keep   = (m_left > 0);
                    end
                end
                else if (in_burst && t == IDLE)   keep = 1'b0;
                else begin
                    m_left = 0; m_incr = 1'b0;
                    if (t == NS && fixed_len(b) > 0) begin
                        m_left = fixed_len(b) - 1; keep = 1'b1;
                    end else if (b == 3'b001 && t != IDLE) begin
                        m_incr = 1'b1; keep = 1'b1;
                    end
                end
            end
            if (!keep) begin
                prev    = m_owner;
                m_owner = pick();
                m_left  = 0; m_incr = 1'b0; m_lock = 1'b0;
                if (m_owner >= 0 && m_owner != prev) m_ptr = m_owner;
            end
        end
    endtask

    task automatic step();
        exp_t         e;
        logic [M-1:0] one;
        one = 1;
        model_edge();
        e.cyc = cycle + 1;
        e.g   = (m_owner >= 0) ? (one << m_owner) : '0;
        e.id  = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
        e.v   = (m_owner >= 0);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic check_now(input string name, input logic [M-1:0] g,
                             input logic [1:0] id, input logic v);
        checks++;
        if (ifc.grant_o !== g || ifc.grant_id_o !== id || ifc.grant_valid_o !== v) begin
            errors++;
            $display("FAIL %s: got grant=%b id=%0d valid=%b, want grant=%b id=%0d valid=%b",
                     name, ifc.grant_o, ifc.grant_id_o, ifc.grant_valid_o, g, id, v);
        end
    endtask

    task automatic set_m(input int i, input logic s, input logic [1:0] p,
                         input logic [1:0] t, input logic [2:0] b, input logic l);
        hsel[i]           = s;
        pri_v[i*PB +: PB] = p;
        trans_v[2*i +: 2] = t;
        burst_v[3*i +: 3] = b;
        lock[i]           = l;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cycle) begin
                e = sb.pop_front();
                checks++;
                if (ifc.grant_o !== e.g || ifc.grant_id_o !== e.id || ifc.grant_valid_o !== e.v) begin
                    errors++;
                    $display("FAIL scoreboard cyc %0d: got grant=%b id=%0d valid=%b, want grant=%b id=%0d valid=%b",
                             e.cyc, ifc.grant_o, ifc.grant_id_o, ifc.grant_valid_o, e.g, e.id, e.v);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL timeout: simulation did not finish, pending=%0d", sb.size());
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [1:0] tie_id;
        rst = 1'b1; hready = 1'b1;
        hsel = '0; lock = '0; pri_v = '0; trans_v = '0; burst_v = '0;
        step(); step();
        check_now("reset", 3'b000, 2'd0, 1'b0);
        rst = 1'b0;
        step();
        check_now("no_request", 3'b000, 2'd0, 1'b0);

        set_m(0, 0, 0, NS, 3'b000, 0);
        set_m(1, 1, 1, NS, 3'b000, 0);
        set_m(2, 1, 2, NS, 3'b000, 0);
        step();
        check_now("first_grant", 3'b100, 2'd2, 1'b1);

        // INCR4 owned by the lowest-priority master, with a BUSY and a stall.
        set_m(2, 0, 2, IDLE, 3'b000, 0);
        set_m(1, 0, 1, IDLE, 3'b000, 0);
        set_m(0, 1, 0, IDLE, 3'b000, 0);
        step();  check_now("m0_grant", 3'b001, 2'd0, 1'b1);
        set_m(0, 1, 0, NS, 3'b011, 0);
        step();  check_now("incr4_beat1", 3'b001, 2'd0, 1'b1);
        set_m(2, 1, 2, NS, 3'b000, 0);
        set_m(0, 1, 0, SEQ, 3'b011, 0);
        step();  check_now("incr4_beat2", 3'b001, 2'd0, 1'b1);
        set_m(0, 1, 0, BUSY, 3'b011, 0);
        step();  check_now("incr4_busy", 3'b001, 2'd0, 1'b1);
        set_m(0, 1, 0, SEQ, 3'b011, 0);
        hready = 1'b0;
        step();  check_now("incr4_stall", 3'b001, 2'd0, 1'b1);
        hready = 1'b1;
        step();  check_now("incr4_beat3", 3'b001, 2'd0, 1'b1);
        step();  check_now("incr4_handover", 3'b100, 2'd2, 1'b1);

        // Locked sequence from master1 against higher-priority master2.
        set_m(0, 0, 0, IDLE, 3'b000, 0);
        set_m(2, 0, 2, IDLE, 3'b000, 0);
        set_m(1, 1, 1, NS, 3'b000, 1);
        step();  check_now("lock_grant", 3'b010, 2'd1, 1'b1);
        set_m(2, 1, 2, NS, 3'b000, 0);
        for (int k = 0; k < 5; k++) begin
            step();  check_now("lock_hold", 3'b010, 2'd1, 1'b1);
        end
        set_m(1, 1, 1, NS, 3'b000, 0);
        step();  check_now("lock_release", 3'b100, 2'd2, 1'b1);

        // Equal priorities with single transfers.
        for (int i = 0; i < M; i++) set_m(i, 1, 1, NS, 3'b000, 0);
        for (int k = 0; k < 4; k++) begin
`ifdef AHB3LITE_SLAVE_ARB_RR_EN
            tie_id = 2'(k % 3);
`else
            tie_id = 2'd0;
`endif
            step();
            check_now("tie_break", 3'b001 << tie_id, tie_id, 1'b1);
        end

        // INCR8 cut short by the owner dropping HSEL.
        set_m(0, 1, 2, NS, 3'b101, 0);
        set_m(1, 1, 1, NS, 3'b000, 0);
        set_m(2, 0, 0, IDLE, 3'b000, 0);
        step();  check_now("incr8_beat1", 3'b001, 2'd0, 1'b1);
        set_m(0, 1, 2, SEQ, 3'b101, 0);
        step();  check_now("incr8_beat2", 3'b001, 2'd0, 1'b1);
        step();  check_now("incr8_beat3", 3'b001, 2'd0, 1'b1);
        set_m(0, 0, 2, SEQ, 3'b101, 0);
        step();  check_now("incr8_drop", 3'b010, 2'd1, 1'b1);

        // Reset while locked, with HREADY low.
        set_m(1, 1, 1, NS, 3'b000, 1);
        step();  check_now("lock2_enter", 3'b010, 2'd1, 1'b1);
        step();  check_now("lock2_hold", 3'b010, 2'd1, 1'b1);
        rst = 1'b1; hready = 1'b0;
        step();  check_now("reset_in_lock", 3'b000, 2'd0, 1'b0);
        rst = 1'b0;
        step();  check_now("idle_after_reset", 3'b000, 2'd0, 1'b0);
        hready = 1'b1;
        step();  check_now("regrant", 3'b010, 2'd1, 1'b1);

        // Randomised traffic checked by the scoreboard.
        for (int n = 0; n < 2000; n++) begin
            rst    = ($urandom_range(0, 99) == 0);
            hready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < M; i++)
                set_m(i, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                      2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                      ($urandom_range(0, 7) == 0));
            step();
        end
        rst = 1'b0; hready = 1'b1;
        step();

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
